// File: rtl/rst_seq_pkg.sv
// +------------------------------------------------------------------+
// | rst_seq_pkg: shared types and helpers for the reset sequencer     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rst_seq_pkg;

  localparam int c_state_w = 3;

  typedef enum logic [c_state_w-1:0] {
    HOLD     = 3'd0,
    WAIT_RDY = 3'd1,
    GAP      = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } seq_state_e;

  // Index width for a domain count; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_cnt.sv
// +------------------------------------------------------------------+
// | rst_seq_cnt: loadable up-counter with clear and terminal compare  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rst_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt     = r_cnt;
  assign at_term = (r_cnt == term_val);

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// +------------------------------------------------------------------+
// | rst_seq_ctrl: ordered per-domain reset release with ready wait,   |
// | inter-release gap and optional watchdog (RST_SEQ_TIMEOUT_EN).     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int  NUM_DOMAINS    = 4,
  parameter int  GAP_CYCLES     = 8,
  parameter int  TIMEOUT_CYCLES = 255,
  parameter int  CNT_W          = 8,
  localparam int IDX_W          = idx_width(NUM_DOMAINS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       err_idx
);

  localparam logic [CNT_W-1:0] c_gap_term = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_to_term  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             r_state;
  seq_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [IDX_W-1:0]       w_idx_inc;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_at_term;
  logic [CNT_W-1:0]       w_term;
  logic [CNT_W-1:0]       w_cnt;

`ifdef RST_SEQ_TIMEOUT_EN
  logic                   r_err;
  logic                   w_err_nxt;
  logic [IDX_W-1:0]       r_err_idx;
  logic [IDX_W-1:0]       w_err_idx_nxt;
`endif

  // One counter serves both the gap timer and the ready watchdog.
  assign w_term    = (r_state == WAIT_RDY) ? c_to_term : c_gap_term;
  assign w_idx_inc = r_idx + IDX_W'(1);

  rst_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_cnt_clr),
    .load     (1'b0),
    .inc      (w_cnt_inc),
    .load_val ({CNT_W{1'b0}}),
    .term_val (w_term),
    .cnt      (w_cnt),
    .at_term  (w_at_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HOLD;
      r_idx     <= '0;
      r_rst_n   <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      r_err     <= 1'b0;
      r_err_idx <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
`ifdef RST_SEQ_TIMEOUT_EN
      r_err     <= w_err_nxt;
      r_err_idx <= w_err_idx_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_rst_n_nxt   = r_rst_n;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    w_err_nxt     = r_err;
    w_err_idx_nxt = r_err_idx;
`endif

    if (sw_rst_req) begin
      // Software restart mirrors hardware reset and holds the counter at zero.
      w_state_nxt   = HOLD;
      w_idx_nxt     = '0;
      w_rst_n_nxt   = '0;
      w_cnt_clr     = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
      w_err_nxt     = 1'b0;
      w_err_idx_nxt = '0;
`endif
    end else begin
      case (r_state)
        HOLD: begin
          if (w_at_term) begin
            w_rst_n_nxt[0] = 1'b1;
            w_idx_nxt      = '0;
            w_cnt_clr      = 1'b1;
            w_state_nxt    = WAIT_RDY;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end

        WAIT_RDY: begin
          if (dom_ready[r_idx]) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = (r_idx == c_last_idx) ? DONE : GAP;
          end else begin
`ifdef RST_SEQ_TIMEOUT_EN
            if (w_at_term) begin
              w_cnt_clr     = 1'b1;
              w_err_nxt     = 1'b1;
              w_err_idx_nxt = r_idx;
              w_state_nxt   = ERROR;
            end else begin
              w_cnt_inc = 1'b1;
            end
`endif
          end
        end

        GAP: begin
          if (w_at_term) begin
            w_idx_nxt              = w_idx_inc;
            w_rst_n_nxt[w_idx_inc] = 1'b1;
            w_cnt_clr              = 1'b1;
            w_state_nxt            = WAIT_RDY;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end

        DONE: begin
          w_state_nxt = DONE;
        end

`ifdef RST_SEQ_TIMEOUT_EN
        ERROR: begin
          w_state_nxt = ERROR;
        end
`endif

        default: begin
          w_state_nxt = HOLD;
          w_rst_n_nxt = '0;
          w_idx_nxt   = '0;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != DONE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign dom_rst_n = r_rst_n;
  assign seq_busy  = r_busy;
  assign seq_done  = r_done;

`ifdef RST_SEQ_TIMEOUT_EN
  assign timeout_err = r_err;
  assign err_idx     = r_err_idx;
`else
  assign timeout_err = 1'b0;
  assign err_idx     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// +------------------------------------------------------------------+
// | tb_rst_seq_ctrl: scoreboard bench for the reset sequencer         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_rst_seq_ctrl;

  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TO  = 255;
  localparam int CW  = 8;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] lb_mask    = 4'hf;
  logic [3:0] rdy_force  = 4'h0;
  logic [3:0] dom_ready;
  logic [3:0] dom_rst_n;
  logic       seq_busy;
  logic       seq_done;
  logic       timeout_err;
  logic [1:0] err_idx;

  assign dom_ready = (dom_rst_n & lb_mask) | rdy_force;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_DOMAINS    (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .dom_ready   (dom_ready),
    .dom_rst_n   (dom_rst_n),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .err_idx     (err_idx)
  );

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   e           = 0;

  localparam logic [8:0] c_reset_vec = {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};

  // Expected {dom_rst_n, busy, done, err, err_idx} after edge ev, sequence
  // starting at edge s; stall is the domain that never becomes ready (4 = none).
  function automatic logic [8:0] model(int ev, int s, int stall, bit err_en);
    logic [3:0] rn = 4'b0000;
    logic       done;
    logic       err;
    logic [1:0] ei;
    for (int k = 0; k < 4; k++)
      if (k <= stall && ev >= s + GAP + (GAP + 1) * k) rn[k] = 1'b1;
    done = (stall >= 4) && (ev >= s + GAP + (GAP + 1) * 3 + 1);
    err  = err_en && (stall < 4) && (ev >= s + GAP + (GAP + 1) * stall + TO);
    ei   = err ? 2'(stall) : 2'd0;
    return {rn, ~done, done, err, ei};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic push(input string tag, input logic [8:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t       x;
    logic [8:0] obs;
    obs = {dom_rst_n, seq_busy, seq_done, timeout_err, err_idx};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %b expected <entry>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.v) else begin
        miscompares++;
        $error("FAIL %s edge %0d: observed %b expected %b", x.tag, e, obs, x.v);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    push("reset", c_reset_vec);
    check();
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic run(input string tag, input int upto, input int s, input int stall, input bit err_en);
    while (e < upto) begin
      push(tag, model(e + 1, s, stall, err_en));
      step();
      check();
    end
  endtask

  initial begin
    #1;
    // Loopback release order and completion
    do_reset(3);
    run("loopback", 40, 0, 4, 1'b0);

    // Single-cycle reset from DONE, then the same sequence again
    do_reset(1);
    run("rerun", 40, 0, 4, 1'b0);

    // Software restart pulse mid-sequence
    do_reset(1);
    run("pre_sw", 19, 0, 4, 1'b0);
    sw_rst_req = 1'b1;
    push("sw_pulse", c_reset_vec);
    step();
    check();
    sw_rst_req = 1'b0;
    run("post_sw", 60, 20, 4, 1'b0);

    // Ready already high: gap must still be honoured
    lb_mask   = 4'h0;
    rdy_force = 4'hf;
    do_reset(2);
    run("early_rdy", 40, 0, 4, 1'b0);

`ifdef RST_SEQ_TIMEOUT_EN
    // Domain 2 never ready: watchdog fires, released domains hold
    lb_mask   = 4'b1011;
    rdy_force = 4'h0;
    do_reset(2);
    run("timeout", 285, 0, 2, 1'b1);
    sw_rst_req = 1'b1;
    push("sw_clr_err", c_reset_vec);
    step();
    check();
    push("sw_held", c_reset_vec);
    step();
    check();
    sw_rst_req = 1'b0;
    e = 0;
    run("after_err", 10, 0, 2, 1'b1);
`else
    // Domain 1 never ready: waits forever without error
    lb_mask   = 4'b1101;
    rdy_force = 4'h0;
    do_reset(2);
    run("no_wdog", 1000, 0, 1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
